// File: rtl/fp_exec_sequencer.sv
// fp_exec_sequencer
//   Drives the shared multi-cycle FPU for ADD_S/SUB_S/MUL_S/DIV_S. It takes one
//   op from decode, holds the FPU operands steady for the op's latency, stalls
//   the pipeline meanwhile, then issues a single-cycle FP register writeback.
//   The writeback waits while the pipeline is frozen by ext_stall_i.
//
// Ports
//   clk_i, rst_b_i        clock (rising edge), synchronous active-low reset
//   issue_*_i             op, destination and operands from decode
//   kill_i                flush; aborts any in-flight op
//   ext_stall_i           pipeline frozen (cache miss)
//   fpu_result_i          FPU result, valid in the last RUN cycle
//   fpu_start_o           pulse in the first RUN cycle
//   fpu_op/a/b_o          latched op and operands, stable until next accept
//   stall_req_o, busy_o   freeze request, sequencer not idle
//   wb_valid/addr/data_o  FP register-file write port
//   stall_cycles_o        saturating count of stall_req_o cycles
//
// state  | meaning
// IDLE   | waiting for an FP op from decode
// RUN    | op in flight, counting down its latency
// WB     | result ready, waiting to write back
module fp_exec_sequencer #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 12,
  parameter int CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        issue_valid_i,
  input  logic [1:0]  issue_op_i,
  input  logic [4:0]  issue_fd_i,
  input  logic [31:0] issue_a_i,
  input  logic [31:0] issue_b_i,
  input  logic        kill_i,
  input  logic        ext_stall_i,
  input  logic [31:0] fpu_result_i,
  output logic        fpu_start_o,
  output logic [1:0]  fpu_op_o,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_e;

  localparam logic [CNT_W-1:0] CNT_ADD = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(LAT_DIV - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_init;
  logic [1:0]         op_q;
  logic [4:0]         fd_q;
  logic [31:0]        a_q, b_q, res_q;
  logic               start_q;
  logic [15:0]        stall_cnt_q;
  logic               accept;

  assign accept = (state_q == S_IDLE) && issue_valid_i && !kill_i;

  // Sub shares the adder latency.
  always_comb begin
    cnt_init = CNT_ADD;
    case (issue_op_i)
      2'b10:   cnt_init = CNT_MUL;
      2'b11:   cnt_init = CNT_DIV;
      default: cnt_init = CNT_ADD;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (kill_i)              state_d = S_IDLE;
        else if (cnt_q == '0)    state_d = S_WB;
      end
      S_WB: if (kill_i || !ext_stall_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      cnt_q       <= '0;
      op_q        <= '0;
      fd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      start_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // Flag marks the first RUN cycle for the FPU start pulse.
      start_q <= accept;
      if (accept) begin
        op_q  <= issue_op_i;
        fd_q  <= issue_fd_i;
        a_q   <= issue_a_i;
        b_q   <= issue_b_i;
        cnt_q <= cnt_init;
      end
      if (state_q == S_RUN && !kill_i) begin
        if (cnt_q == '0) res_q <= fpu_result_i;
        else             cnt_q <= cnt_q - 1'b1;
      end
      if (stall_req_o && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Outputs
  always_comb begin
    fpu_start_o    = start_q;
    fpu_op_o       = op_q;
    fpu_a_o        = a_q;
    fpu_b_o        = b_q;
    busy_o         = (state_q != S_IDLE);
    stall_req_o    = (state_q == S_RUN) || (state_q == S_WB && ext_stall_i);
    wb_valid_o     = (state_q == S_WB) && !ext_stall_i && !kill_i;
    wb_addr_o      = fd_q;
    wb_data_o      = res_q;
    stall_cycles_o = stall_cnt_q;
  end

endmodule

// File: tb/tb_fp_exec_sequencer.sv
module tb_fp_exec_sequencer;

  localparam int LAT_ADD = 2;
  localparam int LAT_MUL = 4;
  localparam int LAT_DIV = 12;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_op = '0;
  logic [4:0]  issue_fd = '0;
  logic [31:0] issue_a = '0, issue_b = '0;
  logic        kill = 1'b0, ext_stall = 1'b0;
  logic [31:0] fpu_result = '0;
  logic        fpu_start, stall_req, busy, wb_valid;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, wb_data;
  logic [4:0]  wb_addr;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  logic [1:0]  last_op = '0;
  logic [31:0] last_a = '0, last_b = '0;

  always #5 clk = ~clk;

  fp_exec_sequencer #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .CNT_W(4)) dut (
    .clk_i(clk), .rst_b_i(rst_b), .issue_valid_i(issue_valid), .issue_op_i(issue_op),
    .issue_fd_i(issue_fd), .issue_a_i(issue_a), .issue_b_i(issue_b), .kill_i(kill),
    .ext_stall_i(ext_stall), .fpu_result_i(fpu_result), .fpu_start_o(fpu_start),
    .fpu_op_o(fpu_op), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .stall_req_o(stall_req),
    .busy_o(busy), .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .stall_cycles_o(stall_cycles)
  );

  initial begin
    #5ms;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int lat(input logic [1:0] op);
    case (op)
      2'b10:   return LAT_MUL;
      2'b11:   return LAT_DIV;
      default: return LAT_ADD;
    endcase
  endfunction

  task automatic add_stall(input int n);
    exp_stall = (exp_stall + n > 65535) ? 65535 : exp_stall + n;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},      32'(busy),         32'(0));
    chk({tag, ".stall_req"}, 32'(stall_req),    32'(0));
    chk({tag, ".wb_valid"},  32'(wb_valid),     32'(0));
    chk({tag, ".start"},     32'(fpu_start),    32'(0));
    chk({tag, ".stall_cnt"}, 32'(stall_cycles), 32'(exp_stall));
    chk({tag, ".fpu_op"},    32'(fpu_op),       32'(last_op));
    chk({tag, ".fpu_a"},     fpu_a,             last_a);
    chk({tag, ".fpu_b"},     fpu_b,             last_b);
  endtask

  task automatic check_zero(input string tag);
    check_idle(tag);
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(0));
    chk({tag, ".wb_data"}, wb_data,      32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; issue_valid = 1'b0; kill = 1'b0; ext_stall = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    exp_stall = 0; last_op = '0; last_a = '0; last_b = '0;
    #1 check_zero("reset");
  endtask

  // One transaction. abort_at: 0 none, 1..L kill/reset in that RUN cycle,
  // L+1 kill in the first WB cycle. noise drives random issues while busy.
  task automatic run_op(input logic [1:0] op, input logic [4:0] fd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int hold,
                        input int abort_at, input bit use_rst, input bit noise);
    int L;
    L = lat(op);
    @(negedge clk);
    rst_b = 1'b1; kill = 1'b0; ext_stall = 1'($urandom_range(0, 1));
    issue_valid = 1'b1; issue_op = op; issue_fd = fd; issue_a = a; issue_b = b;
    fpu_result = $urandom;
    #1 check_idle("accept");
    last_op = op; last_a = a; last_b = b;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      issue_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      issue_op = 2'($urandom); issue_fd = 5'($urandom);
      issue_a = $urandom; issue_b = $urandom;
      ext_stall = 1'($urandom_range(0, 1));
      kill  = (abort_at == k) && !use_rst;
      rst_b = !((abort_at == k) && use_rst);
      fpu_result = (k == L) ? res : $urandom;
      #1;
      chk("run.busy",     32'(busy),      32'(1));
      chk("run.stall",    32'(stall_req), 32'(1));
      chk("run.start",    32'(fpu_start), 32'(k == 1));
      chk("run.fpu_op",   32'(fpu_op),    32'(op));
      chk("run.fpu_a",    fpu_a,          a);
      chk("run.fpu_b",    fpu_b,          b);
      chk("run.wb_valid", 32'(wb_valid),  32'(0));
      if (abort_at == k) begin
        if (use_rst) begin
          @(negedge clk);
          rst_b = 1'b1; issue_valid = 1'b0; kill = 1'b0;
          exp_stall = 0; last_op = '0; last_a = '0; last_b = '0;
          #1 check_zero("post_rst");
        end else begin
          add_stall(k);
        end
        return;
      end
    end
    add_stall(L);
    for (int j = 0; j <= hold; j++) begin
      @(negedge clk);
      issue_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      issue_op = 2'($urandom);
      ext_stall = (j < hold);
      kill = (abort_at == L + 1) && (j == 0);
      fpu_result = $urandom;
      #1;
      if (j < 6 || j == hold || kill) begin
        chk("wb.busy",     32'(busy),      32'(1));
        chk("wb.stall",    32'(stall_req), 32'(ext_stall));
        chk("wb.valid",    32'(wb_valid),  32'(!ext_stall && !kill));
        chk("wb.addr",     32'(wb_addr),   32'(fd));
        chk("wb.data",     wb_data,        res);
        chk("wb.start",    32'(fpu_start), 32'(0));
      end
      if (ext_stall) add_stall(1);
      if (kill) return;
    end
  endtask

  initial begin
    int L, ab;
    bit ur;
    repeat (3) @(negedge clk);
    do_reset();

    // mul 1.0 * 2.0
    run_op(2'b10, 5'd7, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 0, 0);
    @(negedge clk); issue_valid = 1'b0; ext_stall = 1'b0;
    #1 chk("mul.stall_cnt", 32'(stall_cycles), 32'(4));

    // div with 3 frozen WB cycles
    run_op(2'b11, 5'd12, $urandom, $urandom, 32'hC0DE1234, 3, 0, 0, 0);
    // div killed in third RUN cycle, then a clean add
    run_op(2'b11, 5'd3, $urandom, $urandom, $urandom, 0, 3, 0, 0);
    run_op(2'b00, 5'd9, $urandom, $urandom, 32'h11112222, 0, 0, 0, 0);
    // add then sub back-to-back with noise issues while busy
    run_op(2'b00, 5'd1, $urandom, $urandom, 32'hAAAA0001, 0, 0, 0, 1);
    run_op(2'b01, 5'd2, $urandom, $urandom, 32'hBBBB0002, 0, 0, 0, 1);

    // issue with kill in IDLE is dropped
    @(negedge clk);
    issue_valid = 1'b1; kill = 1'b1; issue_op = 2'b11; issue_a = $urandom; ext_stall = 1'b0;
    #1 check_idle("drop");
    @(negedge clk);
    issue_valid = 1'b0; kill = 1'b0;
    #1 check_idle("drop_after");

    for (int n = 0; n < 25; n++) begin
      logic [1:0] op;
      op = 2'($urandom);
      L  = lat(op);
      ab = 0; ur = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        ab = $urandom_range(1, L + 1);
        ur = (ab <= L) && ($urandom_range(0, 2) == 0);
      end
      run_op(op, 5'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3), ab, ur,
             1'($urandom_range(0, 1)));
    end

    // reset mid-RUN
    run_op(2'b11, 5'd5, $urandom, $urandom, $urandom, 0, 5, 1, 0);

    // saturation of the stall counter
    run_op(2'b11, 5'd30, $urandom, $urandom, 32'h5A5A5A5A, 70000, 0, 0, 0);
    @(negedge clk); issue_valid = 1'b0; kill = 1'b0; ext_stall = 1'b0;
    #1 chk("sat.stall_cnt", 32'(stall_cycles), 32'h0000FFFF);
    run_op(2'b10, 5'd31, $urandom, $urandom, $urandom, 2, 0, 0, 0);

    @(negedge clk); issue_valid = 1'b0; kill = 1'b0; ext_stall = 1'b0;
    #1 check_idle("final");
    chk("final.sat", 32'(stall_cycles), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
